dense_layer_sequencer: RTL and testbench

//  Sequences one fully-connected layer on a single shared MAC: walks N_OUT neurons x N_IN inputs.

---
 rtl/dense_pkg.sv | 36 +++
 rtl/dense_mac.sv | 35 +++
 rtl/dense_layer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dense_layer_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared constants, FSM state type and output quantisation helper for the
// dense-layer sequencer.
package dense_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_FRAC_SHIFT = 7;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Arithmetic shift, then clamp to the signed range of 'width' bits.
  // The caller truncates the 64-bit result to its output width.
  function automatic logic signed [63:0] sat_q(
    input logic signed [63:0] acc,
    input int unsigned        shift,
    input int unsigned        width
  );
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    q  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (q > hi)      return hi;
    else if (q < lo) return lo;
    else             return q;
  endfunction

endpackage

// File: rtl/dense_mac.sv
// Shared signed multiply-accumulate: load bias or add the sign-extended
// product of the two operands; the accumulator wraps modulo 2^ACC_W.
module dense_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic                     i_accum,
  input  logic signed [ACC_W-1:0]  i_bias,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign o_acc      = r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_bias;
    end else if (i_accum) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Fully-connected layer sequencer over one shared MAC (N_OUT x N_IN walk).
// Define DENSE_RELU_EN to apply ReLU after output saturation.
module dense_layer_sequencer
  import dense_pkg::*;
#(
  parameter int N_IN       = 196,
  parameter int N_OUT      = 32,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  localparam int IN_AW     = $clog2(N_IN),
  localparam int WA_W      = $clog2(N_IN * N_OUT),
  localparam int J_W       = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [WA_W-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [J_W-1:0]           b_addr,
  input  logic signed [ACC_W-1:0]  b_data,
  output logic                     res_we,
  output logic [J_W-1:0]           res_idx,
  output logic [ACC_W-1:0]         res_acc,
  output logic                     out_we,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     layer_done
);

  state_t                  r_state;
  logic [IN_AW-1:0]        r_k;
  logic [J_W-1:0]          r_j;
  logic [WA_W-1:0]         r_wbase;
  logic [IN_AW-1:0]        r_in_addr;
  logic [WA_W-1:0]         r_w_addr;
  logic [J_W-1:0]          r_b_addr;
  logic                    r_res_we;
  logic                    r_out_we;
  logic [J_W-1:0]          r_res_idx;
  logic                    r_busy;
  logic                    r_layer_done;

  logic                    w_load;
  logic                    w_accum;
  logic signed [ACC_W-1:0] w_acc;
  logic [DATA_W-1:0]       w_sat;

  // ROM data lags its address by one cycle: bias arrives at MAC k=0,
  // the product for address k arrives at k+1 (or DRAIN for the last one).
  assign w_load  = (r_state == MAC) && (r_k == '0);
  assign w_accum = ((r_state == MAC) && (r_k != '0)) || (r_state == DRAIN);

  dense_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_accum (w_accum),
    .i_bias  (b_data),
    .i_a     (in_data),
    .i_b     (w_data),
    .o_acc   (w_acc)
  );

  assign w_sat = DATA_W'(sat_q(64'(w_acc), FRAC_SHIFT, DATA_W));

`ifdef DENSE_RELU_EN
  assign out_data = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign out_data = w_sat;
`endif

  assign res_acc    = w_acc;
  assign in_addr    = r_in_addr;
  assign w_addr     = r_w_addr;
  assign b_addr     = r_b_addr;
  assign res_we     = r_res_we;
  assign out_we     = r_out_we;
  assign res_idx    = r_res_idx;
  assign busy       = r_busy;
  assign layer_done = r_layer_done;

  // Addresses are registered for the state being entered, so they are
  // valid for the whole cycle spent in BIAS/MAC and zero elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_j          <= '0;
      r_wbase      <= '0;
      r_in_addr    <= '0;
      r_w_addr     <= '0;
      r_b_addr     <= '0;
      r_res_we     <= 1'b0;
      r_out_we     <= 1'b0;
      r_res_idx    <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_res_we <= 1'b0;
      r_out_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state  <= BIAS;
            r_b_addr <= r_j;
            r_busy   <= 1'b1;
          end
        end
        BIAS: begin
          r_state   <= MAC;
          r_k       <= '0;
          r_in_addr <= '0;
          r_w_addr  <= r_wbase;
          r_b_addr  <= '0;
        end
        MAC: begin
          if (r_k == IN_AW'(N_IN - 1)) begin
            r_state   <= DRAIN;
            r_in_addr <= '0;
            r_w_addr  <= '0;
          end else begin
            r_k       <= r_k + IN_AW'(1);
            r_in_addr <= r_k + IN_AW'(1);
            r_w_addr  <= r_w_addr + WA_W'(1);
          end
        end
        DRAIN: begin
          r_state   <= WRITE;
          r_res_we  <= 1'b1;
          r_out_we  <= 1'b1;
          r_res_idx <= r_j;
        end
        WRITE: begin
          if (r_j == J_W'(N_OUT - 1)) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b1;
          end else begin
            r_state  <= BIAS;
            r_j      <= r_j + J_W'(1);
            r_b_addr <= r_j + J_W'(1);
            r_wbase  <= r_wbase + WA_W'(N_IN);
          end
        end
        DONE: begin
          if (!enable) begin
            r_state      <= IDLE;
            r_layer_done <= 1'b0;
            r_j          <= '0;
            r_wbase      <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer: table of full-layer runs with
// hand-computed results, plus reset and enable-handling sequences.
module tb_dense_layer_sequencer;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [7:0]         in_addr;
  logic signed [15:0] in_data;
  logic [12:0]        w_addr;
  logic signed [15:0] w_data;
  logic [4:0]         b_addr;
  logic signed [31:0] b_data;
  logic               res_we;
  logic [4:0]         res_idx;
  logic [31:0]        res_acc;
  logic               out_we;
  logic [15:0]        out_data;
  logic               busy;
  logic               layer_done;

  int total = 0;
  int bad   = 0;

  int in_val = 0;
  int w_val  = 0;
  int b_step = 0;

  typedef struct {
    int          in_v;
    int          w_v;
    int          b_st;
    logic [31:0] acc_base;
    logic [31:0] acc_step;
    logic [15:0] out_base;
    logic [15:0] out_step;
    bit          drop_en;
  } vec_t;

  vec_t vecs[6];

  dense_layer_sequencer dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (enable),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .res_we     (res_we),
    .res_idx    (res_idx),
    .res_acc    (res_acc),
    .out_we     (out_we),
    .out_data   (out_data),
    .busy       (busy),
    .layer_done (layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM/RAM models with one-cycle read latency.
  always @(posedge clk) begin
    in_data <= 16'(in_val);
    w_data  <= 16'(w_val);
    b_data  <= 32'(b_step * int'(b_addr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res_we"},     32'(res_we),     32'd0);
    chk({tag, "_out_we"},     32'(out_we),     32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_layer_done"}, 32'(layer_done), 32'd0);
    chk({tag, "_addrs"},      32'({in_addr, w_addr, b_addr}), 32'd0);
    chk({tag, "_res_idx"},    32'(res_idx),    32'd0);
    chk({tag, "_res_acc"},    res_acc,         32'd0);
    chk({tag, "_out_data"},   32'(out_data),   32'd0);
  endtask

  task automatic run_layer(input int vi);
    vec_t v;
    int   cyc;
    int   nstr;
    v      = vecs[vi];
    in_val = v.in_v;
    w_val  = v.w_v;
    b_step = v.b_st;
    @(posedge clk); #1;
    enable = 1'b1;
    cyc    = 0;
    nstr   = 0;
    while (layer_done !== 1'b1 && cyc < 7000) begin
      @(posedge clk); #1;
      cyc++;
      if (v.drop_en && cyc == 20) enable = 1'b0;
      if (cyc == 1)   chk("busy_start", 32'(busy), 32'd1);
      if (cyc == 198) chk("drain_addr_zero", 32'({in_addr, w_addr}), 32'd0);
      if (cyc == 200) chk("bias_addr_n1", 32'(b_addr), 32'd1);
      if (cyc == 206) begin
        chk("in_addr_n1k5", 32'(in_addr), 32'd5);
        chk("w_addr_n1k5",  32'(w_addr),  32'd201);
      end
      if (res_we === 1'b1 || out_we === 1'b1) begin
        chk("we_pair",    32'({res_we, out_we}), 32'd3);
        chk("strobe_cyc", 32'(cyc), 32'((nstr + 1) * 199));
        chk("res_idx",    32'(res_idx), 32'(nstr));
        chk("res_acc",    res_acc, v.acc_base + v.acc_step * 32'(nstr));
        chk("out_data",   32'(out_data), 32'(16'(v.out_base + v.out_step * 16'(nstr))));
        nstr++;
      end
    end
    chk("done_latency", 32'(cyc), 32'd6369);
    chk("strobe_count", 32'(nstr), 32'd32);
    chk("busy_in_done", 32'(busy), 32'd0);
    if (!v.drop_en) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("done_hold", 32'({layer_done, busy, res_we}), 32'd4);
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    chk("back_idle", 32'({layer_done, busy}), 32'd0);
  endtask

  task automatic reset_mid_run();
    int cyc;
    int nstr;
    in_val = 128;
    w_val  = 1;
    b_step = 0;
    @(posedge clk); #1;
    enable = 1'b1;
    cyc    = 0;
    nstr   = 0;
    while (nstr < 5 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (res_we === 1'b1) nstr++;
    end
    chk("pre_reset_strobes", 32'(nstr), 32'd5);
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("midrun_reset");
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    nstr = 0;
    cyc  = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (res_we === 1'b1 || out_we === 1'b1) nstr++;
      if (busy === 1'b1) cyc++;
    end
    chk("post_reset_strobes", 32'(nstr), 32'd0);
    chk("post_reset_busy",    32'(cyc),  32'd0);
  endtask

  initial begin
    vecs[0] = '{128,    1,     0, 32'd25088,      32'd0,   16'd196,   16'd0, 1'b1};
    vecs[1] = '{128,   -1,     0, 32'hFFFF9E00,   32'd0,   16'hFF3C,  16'd0, 1'b0};
    vecs[2] = '{127,   32767,  0, 32'd815636164,  32'd0,   16'd32767, 16'd0, 1'b0};
    vecs[3] = '{-127,  32767,  0, -32'sd815636164, 32'd0,  16'h8000,  16'd0, 1'b0};
    vecs[4] = '{32767, 32767,  0, -32'sd12844860, 32'd0,   16'h8000,  16'd0, 1'b0};
    vecs[5] = '{0,     5,    128, 32'd0,          32'd128, 16'd0,     16'd1, 1'b0};
`ifdef DENSE_RELU_EN
    vecs[1].out_base = 16'd0;
    vecs[3].out_base = 16'd0;
    vecs[4].out_base = 16'd0;
`endif

    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero("idle_reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_layer(i);

    reset_mid_run();
    run_layer(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
